// File: rtl/lcd_writer_pkg.sv
// Shared states, HD44780 command bytes and frame byte ordering for the
// 4-bit LCD writer.
package lcd_writer_pkg;

  typedef enum logic [2:0] {PWR_WAIT, INIT_NIB, INIT_CMD, IDLE, FRAME} lcd_state_t;
  typedef enum logic [1:0] {SUB_HI, SUB_LO, SUB_WAIT} lcd_sub_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_PULSE, TX_HOLD} lcd_tx_state_t;

  localparam logic [7:0] CMD_FUNC_SET   = 8'h28;
  localparam logic [7:0] CMD_ENTRY_MODE = 8'h06;
  localparam logic [7:0] CMD_DISP_ON    = 8'h0C;
  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CMD_LINE1      = 8'h80;
  localparam logic [7:0] CMD_LINE2      = 8'hC0;

  localparam int FRAME_LEN    = 34;
  localparam int INIT_SEQ_LEN = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [3:0] init_nib(input logic [5:0] i);
    return (i == 6'd3) ? 4'h2 : 4'h3;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [5:0] i);
    logic [7:0] b;
    case (i[1:0])
      2'd0:    b = CMD_FUNC_SET;
      2'd1:    b = CMD_ENTRY_MODE;
      2'd2:    b = CMD_DISP_ON;
      default: b = CMD_CLEAR;
    endcase
    return b;
  endfunction

  // Returns {rs, byte}: 0x80, chars 0..15, 0xC0, chars 16..31.
  function automatic logic [8:0] frame_item(input logic [5:0] i, input logic [255:0] fb);
    logic [8:0] item;
    logic [4:0] ch;
    if (i < 6'd17) ch = 5'(i - 6'd1);
    else           ch = 5'(i - 6'd2);
    if (i == 6'd0)       item = {1'b0, CMD_LINE1};
    else if (i == 6'd17) item = {1'b0, CMD_LINE2};
    else                 item = {1'b1, fb[{ch, 3'b000} +: 8]};
    return item;
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Drives one 4-bit nibble onto the LCD bus: setup with E low, E pulse,
// then hold with E low. Nibbles can be chained back to back without gaps.
module lcd_nibble_tx
  import lcd_writer_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int E_PULSE_CYC = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rs,
  input  logic [3:0] nibble,
  output logic       done,
  output logic       lcdE,
  output logic       lcdRs,
  output logic [3:0] lcdDb
);

  localparam int TX_W = $clog2(max2(SETUP_CYC, E_PULSE_CYC) + 1);

  lcd_tx_state_t   txState;
  logic [TX_W-1:0] cnt;

  // start/done handshake: start is taken while idle or on the done cycle
  // (back-to-back); done is high for exactly the last hold cycle.
  assign done = (txState == TX_HOLD) && (cnt == TX_W'(SETUP_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txState <= TX_IDLE;
      cnt     <= '0;
      lcdE    <= 1'b0;
      lcdRs   <= 1'b0;
      lcdDb   <= '0;
    end else begin
      case (txState)
        TX_IDLE: begin
          if (start) begin
            lcdRs   <= rs;
            lcdDb   <= nibble;
            cnt     <= '0;
            txState <= TX_SETUP;
          end
        end
        TX_SETUP: begin
          if (cnt == TX_W'(SETUP_CYC - 1)) begin
            cnt     <= '0;
            lcdE    <= 1'b1;
            txState <= TX_PULSE;
          end else cnt <= cnt + TX_W'(1);
        end
        TX_PULSE: begin
          if (cnt == TX_W'(E_PULSE_CYC - 1)) begin
            cnt     <= '0;
            lcdE    <= 1'b0;
            txState <= TX_HOLD;
          end else cnt <= cnt + TX_W'(1);
        end
        TX_HOLD: begin
          if (done) begin
            cnt <= '0;
            if (start) begin
              lcdRs   <= rs;
              lcdDb   <= nibble;
              txState <= TX_SETUP;
            end else txState <= TX_IDLE;
          end else cnt <= cnt + TX_W'(1);
        end
        default: txState <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/i2c_slave_lcd_writer.sv
// HD44780 4-bit writer: power-on init, then 34-byte frame rewrites on request.
// Optional LCD_WRITER_AUTO_REFRESH_EN adds a periodic internal refresh.
module i2c_slave_lcd_writer
  import lcd_writer_pkg::*;
#(
  parameter int POWERON_CYC   = 750000,
  parameter int INIT_WAIT_CYC = 205000,
  parameter int SETUP_CYC     = 2,
  parameter int E_PULSE_CYC   = 12,
  parameter int CMD_WAIT_CYC  = 2000,
  parameter int CLR_WAIT_CYC  = 82000,
  parameter int REFRESH_CYC   = 2500000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] lcd_data,
  input  logic         refresh,
  output logic         busy,
  output logic         lcd_e,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [3:0]   lcd_db
);

  localparam int MAX_CYC = max2(max2(max2(POWERON_CYC, INIT_WAIT_CYC), max2(CMD_WAIT_CYC, CLR_WAIT_CYC)), REFRESH_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  lcd_state_t       state;
  lcd_sub_t         sub;
  logic [5:0]       idx, nextIdx;
  logic [CNT_W-1:0] cnt;
  logic             pending;
  logic [255:0]     frameBuf;
  logic [8:0]       curItem, nextItem, selItem;
  logic             lastItem, waitTerm, trigger;
  logic             nibStart, nibRs, nibDone;
  logic [3:0]       nibVal;

  assign lcd_rw = 1'b0;

`ifdef LCD_WRITER_AUTO_REFRESH_EN
  logic             autoRun, autoPulse;
  logic [CNT_W-1:0] autoCnt;

  assign autoPulse = autoRun && (autoCnt == CNT_W'(REFRESH_CYC - 1));
  assign trigger   = refresh | autoPulse;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      autoRun <= 1'b0;
      autoCnt <= '0;
    end else begin
      if (state == INIT_CMD && sub == SUB_WAIT && waitTerm && lastItem) autoRun <= 1'b1;
      if (autoRun) autoCnt <= autoPulse ? '0 : autoCnt + CNT_W'(1);
    end
  end
`else
  assign trigger = refresh;
`endif

  always_comb begin
    nextIdx = idx + 6'd1;
    if (state == FRAME) begin
      curItem  = frame_item(idx, frameBuf);
      nextItem = frame_item(nextIdx, frameBuf);
      lastItem = (idx == 6'(FRAME_LEN - 1));
    end else begin
      curItem  = {1'b0, init_cmd(idx)};
      nextItem = {1'b0, init_cmd(nextIdx)};
      lastItem = (idx == 6'(INIT_SEQ_LEN - 1));
    end
    selItem = (sub == SUB_WAIT) ? nextItem : curItem;
    case (state)
      PWR_WAIT: waitTerm = (cnt == CNT_W'(POWERON_CYC - 1));
      INIT_NIB: waitTerm = (cnt == CNT_W'(INIT_WAIT_CYC - 1));
      default:  waitTerm = (curItem == {1'b0, CMD_CLEAR}) ? (cnt == CNT_W'(CLR_WAIT_CYC - 1))
                                                          : (cnt == CNT_W'(CMD_WAIT_CYC - 1));
    endcase
  end

  // Nibble starts are issued in the cycle before they appear on the bus, so
  // consecutive nibbles and waits chain without idle cycles.
  always_comb begin
    nibStart = 1'b0;
    nibRs    = 1'b0;
    nibVal   = '0;
    case (state)
      PWR_WAIT: if (waitTerm) begin
        nibStart = 1'b1;
        nibVal   = init_nib(6'd0);
      end
      INIT_NIB: if (sub == SUB_WAIT && waitTerm) begin
        nibStart = 1'b1;
        nibVal   = lastItem ? CMD_FUNC_SET[7:4] : init_nib(nextIdx);
      end
      INIT_CMD, FRAME: if ((sub == SUB_HI && nibDone) || (sub == SUB_WAIT && waitTerm && !lastItem)) begin
        nibStart = 1'b1;
        nibRs    = selItem[8];
        nibVal   = (sub == SUB_WAIT) ? selItem[7:4] : selItem[3:0];
      end
      IDLE: if (pending || trigger) begin
        nibStart = 1'b1;
        nibVal   = CMD_LINE1[7:4];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= PWR_WAIT;
      sub      <= SUB_HI;
      idx      <= '0;
      cnt      <= '0;
      pending  <= 1'b0;
      busy     <= 1'b1;
      frameBuf <= '0;
    end else begin
      if (trigger && state != IDLE) pending <= 1'b1;
      case (state)
        PWR_WAIT: begin
          if (waitTerm) begin
            state <= INIT_NIB;
            idx   <= '0;
            sub   <= SUB_LO;
            cnt   <= '0;
          end else cnt <= cnt + CNT_W'(1);
        end
        INIT_NIB: begin
          if (sub == SUB_WAIT) begin
            if (waitTerm) begin
              cnt <= '0;
              if (lastItem) begin
                state <= INIT_CMD;
                idx   <= '0;
                sub   <= SUB_HI;
              end else begin
                idx <= nextIdx;
                sub <= SUB_LO;
              end
            end else cnt <= cnt + CNT_W'(1);
          end else if (nibDone) begin
            sub <= SUB_WAIT;
            cnt <= '0;
          end
        end
        INIT_CMD, FRAME: begin
          case (sub)
            SUB_HI: if (nibDone) sub <= SUB_LO;
            SUB_LO: if (nibDone) begin
              sub <= SUB_WAIT;
              cnt <= '0;
            end
            default: begin
              if (waitTerm) begin
                cnt <= '0;
                if (lastItem) begin
                  state <= IDLE;
                  // Init always chains into one frame; otherwise busy drops
                  // only if no request is waiting.
                  if (state == INIT_CMD) pending <= 1'b1;
                  else                   busy    <= pending || trigger;
                end else begin
                  idx <= nextIdx;
                  sub <= SUB_HI;
                end
              end else cnt <= cnt + CNT_W'(1);
            end
          endcase
        end
        IDLE: begin
          if (pending || trigger) begin
            state    <= FRAME;
            idx      <= '0;
            sub      <= SUB_HI;
            frameBuf <= lcd_data;
            pending  <= 1'b0;
            busy     <= 1'b1;
          end
        end
        default: state <= PWR_WAIT;
      endcase
    end
  end

  lcd_nibble_tx #(
    .SETUP_CYC  (SETUP_CYC),
    .E_PULSE_CYC(E_PULSE_CYC)
  ) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .start (nibStart),
    .rs    (nibRs),
    .nibble(nibVal),
    .done  (nibDone),
    .lcdE  (lcd_e),
    .lcdRs (lcd_rs),
    .lcdDb (lcd_db)
  );

endmodule
